// File: rtl/data_ram.sv
// Word-organised data memory with byte-lane writes, 1-cycle registered reads,
// a post-reset clear sequencer and a registered display/test read port.
module data_ram #(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_err,
    input  logic [31:0] test_addr,
    output logic [31:0] test_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_idx;
    logic [ADDR_W-1:0] test_idx;
    logic              addr_oor;
    logic              test_oor;
    logic              unused_bits;

    // Byte offsets are resolved by the MEM stage; only word index and range matter here.
    assign addr_idx    = dm_addr[ADDR_W+1:2];
    assign test_idx    = test_addr[ADDR_W+1:2];
    assign addr_oor    = |dm_addr[31:ADDR_W+2];
    assign test_oor    = |test_addr[31:ADDR_W+2];
    assign unused_bits = ^{dm_addr[1:0], test_addr[1:0]};

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == S_CLEAR) begin
            cnt_next = cnt + 1'b1;
            if (cnt == '1) begin
                state_next = S_RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            cnt       <= '0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
            test_data <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dm_ready  <= (state_next == S_RUN);
            dm_rdata  <= ((state == S_RUN) && !addr_oor) ? mem[addr_idx] : '0;
            dm_err    <= (state == S_RUN) && addr_oor;
            test_data <= test_oor ? '0 : mem[test_idx];
        end
    end

    // NOTE: the array has no reset; zeroing is done by the CLEAR sequence so it maps to RAM.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= '0;
            end else if (!addr_oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (dm_wen[i]) begin
                        mem[addr_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram (ADDR_W=4): clear sequence, byte lanes,
// read-first behaviour, range errors, reset mid-clear and the no-clear variant.
module tb_data_ram;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dm_addr, dm_wdata, test_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_rdata, test_data;
    logic        dm_ready, dm_err;

    logic [31:0] n_addr, n_wdata, n_test_addr;
    logic [3:0]  n_wen;
    logic [31:0] n_rdata, n_test_data;
    logic        n_ready, n_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_ram #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .dm_addr   (dm_addr),
        .dm_wen    (dm_wen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .dm_err    (dm_err),
        .test_addr (test_addr),
        .test_data (test_data)
    );

    data_ram #(.ADDR_W(4), .CLEAR_ON_RESET(1'b0)) u_noclr (
        .clk       (clk),
        .resetn    (resetn),
        .dm_addr   (n_addr),
        .dm_wen    (n_wen),
        .dm_wdata  (n_wdata),
        .dm_rdata  (n_rdata),
        .dm_ready  (n_ready),
        .dm_err    (n_err),
        .test_addr (n_test_addr),
        .test_data (n_test_data)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] taddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_test;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [31:0] addr, logic [3:0] wen,
                                logic [31:0] wdata, logic [31:0] taddr,
                                logic [31:0] exp_rdata, logic exp_err, logic [31:0] exp_test);
        vec_t v;
        v.name = name; v.addr = addr; v.wen = wen; v.wdata = wdata; v.taddr = taddr;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_test = exp_test;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dm_addr = '0; dm_wen = '0; dm_wdata = '0; test_addr = '0;
        n_addr = '0; n_wen = '0; n_wdata = '0; n_test_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ready_early;
        int cycles;
        int bad;

        idle_inputs();
        resetn = 1'b0;
        tick(); tick();
        check("reset_ready",  {31'b0, dm_ready}, 32'h0);
        check("reset_rdata",  dm_rdata, 32'h0);
        check("reset_err",    {31'b0, dm_err}, 32'h0);
        check("reset_test",   test_data, 32'h0);
        check("noclr_reset_ready", {31'b0, n_ready}, 32'h0);

        // T1: clear lasts 16 cycles; host writes and the no-clear instance run alongside.
        dm_addr = 32'h04; dm_wen = 4'hF; dm_wdata = 32'hFFFF_FFFF;
        n_addr = 32'h08; n_wen = 4'hF; n_wdata = 32'hCAFE_F00D;
        resetn = 1'b1;
        ready_early = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k < 15 && dm_ready !== 1'b0) ready_early++;
            if (dm_rdata !== 32'h0 || dm_err !== 1'b0) bad++;
            if (k == 0) begin
                check("noclr_ready_first_edge", {31'b0, n_ready}, 32'h1);
                n_wen = 4'h0;
            end
            if (k == 1) check("noclr_readback", n_rdata, 32'hCAFE_F00D);
        end
        check("clear_ready_low_cycles", ready_early, 0);
        check("clear_outputs_quiet", bad, 0);
        check("clear_ready_after_16", {31'b0, dm_ready}, 32'h1);

        dm_wen = 4'h0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            dm_addr = 32'(i * 4);
            test_addr = 32'((15 - i) * 4);
            tick();
            if (dm_rdata !== 32'h0 || test_data !== 32'h0) bad++;
        end
        check("clear_all_words_zero", bad, 0);

        // T2..T5 as a vector table; expected read data is the pre-write word (read-first).
        vecs.push_back(mk("t2_write",        32'h0C, 4'hF, 32'hDEAD_BEEF, 32'h0C, 32'h0,         1'b0, 32'h0));
        vecs.push_back(mk("t2_read",         32'h0C, 4'h0, 32'h0,         32'h0C, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk("t3_init",         32'h10, 4'hF, 32'h1122_3344, 32'h0C, 32'h0,         1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk("t3_lane2",        32'h10, 4'h4, 32'h00AA_0000, 32'h10, 32'h1122_3344, 1'b0, 32'h1122_3344));
        vecs.push_back(mk("t3_lane10",       32'h10, 4'h3, 32'h0000_BBCC, 32'h10, 32'h11AA_3344, 1'b0, 32'h11AA_3344));
        vecs.push_back(mk("t3_read",         32'h10, 4'h0, 32'h0,         32'h13, 32'h11AA_BBCC, 1'b0, 32'h11AA_BBCC));
        vecs.push_back(mk("t4_init",         32'h20, 4'hF, 32'h1,         32'h00, 32'h0,         1'b0, 32'h0));
        vecs.push_back(mk("t4_rdw",          32'h20, 4'hF, 32'h2,         32'h20, 32'h1,         1'b0, 32'h1));
        vecs.push_back(mk("t4_after",        32'h20, 4'h0, 32'h0,         32'h20, 32'h2,         1'b0, 32'h2));
        vecs.push_back(mk("t5_oor_write",    32'h40, 4'hF, 32'hFFFF_FFFF, 32'h40, 32'h0,         1'b1, 32'h0));
        vecs.push_back(mk("t5_alias_intact", 32'h00, 4'h0, 32'h0,         32'h00, 32'h0,         1'b0, 32'h0));
        vecs.push_back(mk("last_word_write", 32'h3C, 4'h8, 32'h7700_0000, 32'h0C, 32'h0,         1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk("last_word_read",  32'h3C, 4'h0, 32'h0,         32'h3C, 32'h7700_0000, 1'b0, 32'h7700_0000));
        vecs.push_back(mk("top_bit_oor",     32'h8000_0000, 4'h0, 32'h0,  32'h10, 32'h0,         1'b1, 32'h11AA_BBCC));
        vecs.push_back(mk("wen0_no_write",   32'h0C, 4'h0, 32'h1234_5678, 32'h0C, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF));
        vecs.push_back(mk("wen0_reread",     32'h0C, 4'h0, 32'h0,         32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0));

        foreach (vecs[i]) begin
            dm_addr = vecs[i].addr; dm_wen = vecs[i].wen; dm_wdata = vecs[i].wdata;
            test_addr = vecs[i].taddr;
            tick();
            check({vecs[i].name, "_rdata"}, dm_rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   {31'b0, dm_err}, {31'b0, vecs[i].exp_err});
            check({vecs[i].name, "_test"},  test_data, vecs[i].exp_test);
        end

        // T6: reset is asynchronous and a mid-clear reset restarts the full sequence.
        dm_addr = 32'h10; dm_wen = 4'h0; test_addr = 32'h0C;
        tick();
        #2 resetn = 1'b0;
        #1;
        check("async_reset_rdata", dm_rdata, 32'h0);
        check("async_reset_test",  test_data, 32'h0);
        check("async_reset_ready", {31'b0, dm_ready}, 32'h0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("mid_clear_not_ready", {31'b0, dm_ready}, 32'h0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cycles = 0;
        while (dm_ready !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        check("restart_clear_cycles", cycles, 16);

        bad = 0;
        for (int i = 0; i < 16; i++) begin
            test_addr = 32'(i * 4);
            tick();
            if (test_data !== 32'h0) bad++;
        end
        check("restart_words_zero", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
